// File: rtl/gmm_pack_color_pipe.sv
// Packs updated GMM cluster records (weight, mean, variance) into the stored
// format (weight, mean, std, cluster count) using a bit-serial integer sqrt.

module gmm_sqrt_lane #(
  parameter int W_WIDTH   = 8,
  parameter int VAR_WIDTH = 16,
  parameter int STD_WIDTH = 8,
  parameter int BIT_W     = 3
) (
  input  logic [STD_WIDTH-1:0] root,
  input  logic [VAR_WIDTH-1:0] var_v,
  input  logic [BIT_W-1:0]     bit_idx,
  input  logic [W_WIDTH-1:0]   w,
  output logic [STD_WIDTH-1:0] root_nxt,
  output logic [STD_WIDTH-1:0] std_pack
);
  logic [STD_WIDTH-1:0] trial;
  logic [VAR_WIDTH-1:0] trial_ext;
  logic [VAR_WIDTH-1:0] trial_sq;

  // trial < 2^STD_WIDTH, so its square always fits VAR_WIDTH bits
  always_comb begin
    trial     = root | (STD_WIDTH'(1) << bit_idx);
    trial_ext = VAR_WIDTH'(trial);
    trial_sq  = trial_ext * trial_ext;
    root_nxt  = (trial_sq <= var_v) ? trial : root;
    if (w == '0)
      std_pack = '0;
    else if (root_nxt == '0)
      std_pack = STD_WIDTH'(1);
    else
      std_pack = root_nxt;
  end
endmodule

module gmm_pack_color_pipe #(
  parameter int N_CLUSTERS  = 3,
  parameter int W_WIDTH     = 8,
  parameter int VAR_WIDTH   = 16,
  parameter int STD_WIDTH   = 8,
  parameter int COLOR_WIDTH = 24,
  parameter int CNT_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              snk_valid,
  output logic                              snk_ready,
  input  logic [N_CLUSTERS*W_WIDTH-1:0]     snk_w,
  input  logic [N_CLUSTERS*COLOR_WIDTH-1:0] snk_color,
  input  logic [N_CLUSTERS*VAR_WIDTH-1:0]   snk_var,
  output logic                              src_valid,
  input  logic                              src_ready,
  output logic [N_CLUSTERS*W_WIDTH-1:0]     src_w,
  output logic [N_CLUSTERS*COLOR_WIDTH-1:0] src_color,
  output logic [N_CLUSTERS*STD_WIDTH-1:0]   src_std,
  output logic [CNT_WIDTH-1:0]              src_clusters_num
);
  localparam int BIT_W = (STD_WIDTH > 1) ? $clog2(STD_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [N_CLUSTERS-1:0][W_WIDTH-1:0]     w_q, w_d, src_w_q, src_w_d;
  logic [N_CLUSTERS-1:0][COLOR_WIDTH-1:0] color_q, color_d, src_color_q, src_color_d;
  logic [N_CLUSTERS-1:0][VAR_WIDTH-1:0]   var_q, var_d;
  logic [N_CLUSTERS-1:0][STD_WIDTH-1:0]   root_q, root_d, root_nxt, std_pack;
  logic [N_CLUSTERS-1:0][STD_WIDTH-1:0]   src_std_q, src_std_d;
  logic [CNT_WIDTH-1:0]                   src_cnt_q, src_cnt_d, cnt;
  logic                                   src_valid_q, src_valid_d;
  logic                                   accept, run;

  for (genvar k = 0; k < N_CLUSTERS; k++) begin : g_lane
    gmm_sqrt_lane #(
      .W_WIDTH(W_WIDTH), .VAR_WIDTH(VAR_WIDTH),
      .STD_WIDTH(STD_WIDTH), .BIT_W(BIT_W)
    ) u_lane (
      .root    (root_q[k]),
      .var_v   (var_q[k]),
      .bit_idx (bit_q),
      .w       (w_q[k]),
      .root_nxt(root_nxt[k]),
      .std_pack(std_pack[k])
    );
  end

  assign snk_ready        = (state_q == IDLE) | ((state_q == DONE) & src_ready);
  assign accept           = snk_valid & snk_ready;
  assign src_valid        = src_valid_q;
  assign src_w            = src_w_q;
  assign src_color        = src_color_q;
  assign src_std          = src_std_q;
  assign src_clusters_num = src_cnt_q;

  // Active clusters form a prefix; the first zero weight ends the count.
  always_comb begin
    run = 1'b1;
    cnt = '0;
    for (int k = 0; k < N_CLUSTERS; k++) begin
      if (run && (w_q[k] != '0)) cnt = cnt + CNT_WIDTH'(1);
      else                       run = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    w_d         = w_q;
    color_d     = color_q;
    var_d       = var_q;
    root_d      = root_q;
    src_valid_d = src_valid_q;
    src_w_d     = src_w_q;
    src_color_d = src_color_q;
    src_std_d   = src_std_q;
    src_cnt_d   = src_cnt_q;

    if (accept) begin
      w_d     = snk_w;
      color_d = snk_color;
      var_d   = snk_var;
      root_d  = '0;
      bit_d   = BIT_W'(STD_WIDTH - 1);
      state_d = CALC;
    end

    case (state_q)
      IDLE: ;
      CALC: begin
        root_d = root_nxt;
        if (bit_q == '0) begin
          state_d     = DONE;
          src_valid_d = 1'b1;
          src_w_d     = w_q;
          src_color_d = color_q;
          src_std_d   = std_pack;
          src_cnt_d   = cnt;
        end else begin
          bit_d = bit_q - BIT_W'(1);
        end
      end
      DONE: begin
        // with snk_valid high the accept path above already chose CALC
        if (src_ready) begin
          src_valid_d = 1'b0;
          if (!snk_valid) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      w_q         <= '0;
      color_q     <= '0;
      var_q       <= '0;
      root_q      <= '0;
      src_valid_q <= 1'b0;
      src_w_q     <= '0;
      src_color_q <= '0;
      src_std_q   <= '0;
      src_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      w_q         <= w_d;
      color_q     <= color_d;
      var_q       <= var_d;
      root_q      <= root_d;
      src_valid_q <= src_valid_d;
      src_w_q     <= src_w_d;
      src_color_q <= src_color_d;
      src_std_q   <= src_std_d;
      src_cnt_q   <= src_cnt_d;
    end
  end
endmodule

// File: tb/tb_gmm_pack_color_pipe.sv
// Directed bench for gmm_pack_color_pipe: hand-computed sqrt/pack results,
// latency, backpressure, back-to-back and mid-calculation reset.

module tb_gmm_pack_color_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [23:0] snk_w = '0;
  logic [71:0] snk_color = '0;
  logic [47:0] snk_var = '0;
  logic        src_valid;
  logic        src_ready = 1'b1;
  logic [23:0] src_w;
  logic [71:0] src_color;
  logic [23:0] src_std;
  logic [1:0]  src_clusters_num;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gmm_pack_color_pipe dut (
    .clk(clk), .rst(rst),
    .snk_valid(snk_valid), .snk_ready(snk_ready),
    .snk_w(snk_w), .snk_color(snk_color), .snk_var(snk_var),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_w(src_w), .src_color(src_color), .src_std(src_std),
    .src_clusters_num(src_clusters_num)
  );

  // Called 1 time unit after an edge; the following edge accepts.
  task automatic send(input logic [23:0] w, input logic [71:0] c, input logic [47:0] v);
    snk_w = w; snk_color = c; snk_var = v; snk_valid = 1'b1;
    @(posedge clk); #1;
    snk_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!src_valid && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", src_valid); end
    total++; if (snk_ready !== 1'b1) begin bad++; $display("FAIL reset_snk_ready got=%b exp=1", snk_ready); end
    total++; if ({src_w, src_color, src_std, src_clusters_num} !== '0) begin bad++;
      $display("FAIL reset_outputs got w=%h c=%h s=%h n=%0d exp all 0", src_w, src_color, src_std, src_clusters_num); end
  endtask

  task automatic test_basic;
    int cyc;
    src_ready = 1'b1;
    send({8'd30, 8'd20, 8'd10}, {24'hAABBCC, 24'h445566, 24'h112233}, {16'd65535, 16'd2, 16'd100});
    total++; if (snk_ready !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", snk_ready); end
    wait_valid(cyc);
    total++; if (cyc != 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", cyc); end
    total++; if (src_std !== {8'd255, 8'd1, 8'd10}) begin bad++; $display("FAIL basic_std got=%h exp=ff010a", src_std); end
    total++; if (src_clusters_num !== 2'd3) begin bad++; $display("FAIL basic_num got=%0d exp=3", src_clusters_num); end
    total++; if (src_w !== {8'd30, 8'd20, 8'd10}) begin bad++; $display("FAIL basic_w got=%h exp=1e140a", src_w); end
    total++; if (src_color !== {24'hAABBCC, 24'h445566, 24'h112233}) begin bad++;
      $display("FAIL basic_color got=%h exp=aabbcc445566112233", src_color); end
    @(posedge clk); #1;
    total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%b exp=0", src_valid); end
  endtask

  task automatic test_unused;
    int cyc;
    send({8'd7, 8'd0, 8'd5}, {24'h0A0B0C, 24'h0D0E0F, 24'h010203}, {16'd49, 16'd50, 16'd0});
    wait_valid(cyc);
    total++; if (cyc != 8) begin bad++; $display("FAIL unused_latency got=%0d exp=8", cyc); end
    total++; if (src_std !== {8'd7, 8'd0, 8'd1}) begin bad++; $display("FAIL unused_std got=%h exp=070001", src_std); end
    total++; if (src_clusters_num !== 2'd1) begin bad++; $display("FAIL unused_num got=%0d exp=1", src_clusters_num); end
    total++; if (src_w !== {8'd7, 8'd0, 8'd5}) begin bad++; $display("FAIL unused_w got=%h exp=070005", src_w); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero;
    int cyc;
    send(24'd0, {24'h123456, 24'h789ABC, 24'hDEF012}, {16'd400, 16'd9, 16'd1});
    wait_valid(cyc);
    total++; if (cyc != 8) begin bad++; $display("FAIL zero_latency got=%0d exp=8", cyc); end
    total++; if (src_std !== 24'd0) begin bad++; $display("FAIL zero_std got=%h exp=000000", src_std); end
    total++; if (src_clusters_num !== 2'd0) begin bad++; $display("FAIL zero_num got=%0d exp=0", src_clusters_num); end
    total++; if (src_color !== {24'h123456, 24'h789ABC, 24'hDEF012}) begin bad++;
      $display("FAIL zero_color got=%h exp=123456789abcdef012", src_color); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int cyc;
    src_ready = 1'b0;
    send({8'd3, 8'd2, 8'd1}, {24'h333333, 24'h222222, 24'h111111}, {16'd4, 16'd9, 16'd16});
    wait_valid(cyc);
    total++; if (cyc != 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (src_valid !== 1'b1 || snk_ready !== 1'b0 || src_std !== {8'd2, 8'd3, 8'd4} ||
                   src_w !== {8'd3, 8'd2, 8'd1} || src_clusters_num !== 2'd3) begin bad++;
        $display("FAIL bp_hold[%0d] got v=%b rdy=%b s=%h w=%h n=%0d exp v=1 rdy=0 s=020304 w=030201 n=3",
                 i, src_valid, snk_ready, src_std, src_w, src_clusters_num); end
    end
    src_ready = 1'b1; #1;
    total++; if (snk_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", snk_ready); end
    @(posedge clk); #1;
    src_ready = 1'b0; #1;
    total++; if (src_valid !== 1'b0 || snk_ready !== 1'b1) begin bad++;
      $display("FAIL bp_idle got v=%b rdy=%b exp v=0 rdy=1", src_valid, snk_ready); end
    src_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    src_ready = 1'b1;
    send({8'd30, 8'd20, 8'd10}, {24'hAABBCC, 24'h445566, 24'h112233}, {16'd65535, 16'd2, 16'd100});
    wait_valid(cyc);
    total++; if (cyc != 8) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=8", cyc); end
    snk_w = {8'd1, 8'd1, 8'd1}; snk_color = {24'hC0FFEE, 24'hBEEF00, 24'hFACADE};
    snk_var = {16'd255, 16'd3, 16'd144}; snk_valid = 1'b1; #1;
    total++; if (snk_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", snk_ready); end
    @(posedge clk); #1;
    snk_valid = 1'b0;
    total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", src_valid); end
    wait_valid(cyc);
    total++; if (cyc + 1 != 9) begin bad++; $display("FAIL b2b_spacing got=%0d exp=9", cyc + 1); end
    total++; if (src_std !== {8'd15, 8'd1, 8'd12}) begin bad++; $display("FAIL b2b_std got=%h exp=0f010c", src_std); end
    total++; if (src_color !== {24'hC0FFEE, 24'hBEEF00, 24'hFACADE}) begin bad++;
      $display("FAIL b2b_color got=%h exp=c0ffeebeef00facade", src_color); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc;
    int cyc;
    send({8'd9, 8'd9, 8'd9}, {24'h555555, 24'h666666, 24'h777777}, {16'd81, 16'd81, 16'd81});
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; #1;
    total++; if (src_valid !== 1'b0 || {src_w, src_color, src_std, src_clusters_num} !== '0) begin bad++;
      $display("FAIL midrst_outputs got v=%b w=%h s=%h n=%0d exp all 0", src_valid, src_w, src_std, src_clusters_num); end
    @(posedge clk); #1; rst = 1'b0; #1;
    total++; if (snk_ready !== 1'b1 || src_valid !== 1'b0) begin bad++;
      $display("FAIL midrst_idle got rdy=%b v=%b exp rdy=1 v=0", snk_ready, src_valid); end
    @(posedge clk); #1;
    send({8'd0, 8'd0, 8'd9}, {24'h0, 24'h0, 24'h909090}, {16'd0, 16'd0, 16'd144});
    wait_valid(cyc);
    total++; if (cyc != 8) begin bad++; $display("FAIL midrst_latency got=%0d exp=8", cyc); end
    total++; if (src_std !== {8'd0, 8'd0, 8'd12}) begin bad++; $display("FAIL midrst_std got=%h exp=00000c", src_std); end
    total++; if (src_clusters_num !== 2'd1) begin bad++; $display("FAIL midrst_num got=%0d exp=1", src_clusters_num); end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic;
    test_unused;
    test_all_zero;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_calc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
